// File: rtl/bias_cal_pkg.sv
// Shared types for the bias calibration sequencer.
// Holds the FSM state encoding and the accumulator width helper.
package bias_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        UPDATE,
        RUN
    } state_t;

    function automatic int acc_width(input int dw, input int sb);
        return dw + sb;
    endfunction

endpackage

// File: rtl/bias_cal_accum.sv
// Sample counter and sign-extending accumulator for the bias sequencer.
// clear has priority over enable; add gates summation only.
module bias_cal_accum
    import bias_cal_pkg::*;
#(
    parameter int DataWidth  = 24,
    parameter int SampleBits = 12,
    parameter int CntWidth   = 13
) (
    input  logic                                              aclk,
    input  logic                                              aresetn,
    input  logic                                              clear,
    input  logic                                              enable,
    input  logic                                              add,
    input  logic [DataWidth-1:0]                              sample,
    output logic signed [acc_width(DataWidth, SampleBits)-1:0] sum,
    output logic [CntWidth-1:0]                               count
);

    localparam int AccW = acc_width(DataWidth, SampleBits);

    logic signed [AccW-1:0] ext;

    assign ext = {{SampleBits{sample[DataWidth-1]}}, sample};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sum   <= '0;
            count <= '0;
        end else if (clear) begin
            sum   <= '0;
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
            if (add) begin
                sum <= sum + ext;
            end
        end
    end

endmodule

// File: rtl/bias_cal_sequencer.sv
// DC bias calibration sequencer with a one-entry corrected-sample output stage.
// Define BIAS_CAL_SAT_EN to saturate out_tdata instead of wrapping.
module bias_cal_sequencer
    import bias_cal_pkg::*;
#(
    parameter int DataWidth     = 24,
    parameter int SampleBits    = 12,
    parameter int SettleSamples = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cal_start,
    output logic                 cal_busy,
    output logic                 cal_done,
    output logic [DataWidth-1:0] bias_out,
    input  logic                 in_tvalid,
    output logic                 in_tready,
    input  logic [DataWidth-1:0] in_tdata,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic [DataWidth-1:0] out_tdata
);

    localparam int AccW   = acc_width(DataWidth, SampleBits);
    localparam int NAcc   = 1 << SampleBits;
    localparam int MaxCnt = (SettleSamples > NAcc) ? SettleSamples : NAcc;
    localparam int CntW   = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] SettleLast =
        CntW'((SettleSamples > 0) ? SettleSamples - 1 : 0);
    localparam logic [CntW-1:0] AccumLast = CntW'(NAcc - 1);

    state_t state, state_n;

    logic                   clear, enable, add, fwd;
    logic signed [AccW-1:0] sum;
    logic [CntW-1:0]        count;
    logic [DataWidth-1:0]   corr;

    bias_cal_accum #(
        .DataWidth  (DataWidth),
        .SampleBits (SampleBits),
        .CntWidth   (CntW)
    ) u_accum (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (clear),
        .enable  (enable),
        .add     (add),
        .sample  (in_tdata),
        .sum     (sum),
        .count   (count)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_tready = 1'b0;
        clear     = 1'b0;
        enable    = 1'b0;
        add       = 1'b0;
        fwd       = 1'b0;
        cal_done  = 1'b0;
        unique case (state)
            IDLE, RUN: begin
                in_tready = !out_tvalid || out_tready;
                fwd       = in_tvalid && in_tready;
                if (cal_start) begin
                    clear   = 1'b1;
                    state_n = (SettleSamples == 0) ? ACCUM : SETTLE;
                end
            end
            SETTLE: begin
                in_tready = 1'b1;
                if (in_tvalid) begin
                    if (count == SettleLast) begin
                        clear   = 1'b1;
                        state_n = ACCUM;
                    end else begin
                        enable = 1'b1;
                    end
                end
            end
            ACCUM: begin
                in_tready = 1'b1;
                if (in_tvalid) begin
                    enable = 1'b1;
                    add    = 1'b1;
                    if (count == AccumLast) begin
                        state_n = UPDATE;
                    end
                end
            end
            UPDATE: begin
                cal_done = 1'b1;
                state_n  = RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    assign cal_busy = (state == SETTLE) || (state == ACCUM) ||
                      (state == UPDATE);

`ifdef BIAS_CAL_SAT_EN
    logic [DataWidth:0] diff;

    always_comb begin
        diff = {in_tdata[DataWidth-1], in_tdata} -
               {bias_out[DataWidth-1], bias_out};
        corr = diff[DataWidth-1:0];
        // Sign bits disagree only when the true difference left the range
        if (diff[DataWidth] != diff[DataWidth-1]) begin
            corr = diff[DataWidth] ? {1'b1, {(DataWidth-1){1'b0}}}
                                   : {1'b0, {(DataWidth-1){1'b1}}};
        end
    end
`else
    assign corr = in_tdata - bias_out;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            bias_out   <= '0;
        end else begin
            if (fwd) begin
                out_tvalid <= 1'b1;
                out_tdata  <= corr;
            end else if (out_tready) begin
                out_tvalid <= 1'b0;
            end
            if (state == UPDATE) begin
                bias_out <= DataWidth'(sum >>> SampleBits);
            end
        end
    end

endmodule

// File: tb/tb_bias_cal_sequencer.sv
// Directed bench for bias_cal_sequencer (DataWidth=24, SampleBits=4, SettleSamples=2).
// Expected values follow BIAS_CAL_SAT_EN when it is defined.
module tb_bias_cal_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cal_start;
    logic        cal_busy;
    logic        cal_done;
    logic [23:0] bias_out;
    logic        in_tvalid;
    logic        in_tready;
    logic [23:0] in_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic [23:0] out_tdata;

    int vectors = 0;
    int errors  = 0;
    int done_cnt = 0;

    typedef struct {
        logic [23:0] din;
        logic [23:0] dout;
    } vec_t;

    vec_t idle_v[3];
    vec_t run_v[4];

    bias_cal_sequencer #(
        .DataWidth     (24),
        .SampleBits    (4),
        .SettleSamples (2)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .cal_start  (cal_start),
        .cal_busy   (cal_busy),
        .cal_done   (cal_done),
        .bias_out   (bias_out),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (cal_done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [23:0] got,
                         input logic [23:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(input logic [23:0] d);
        int n = 0;
        @(negedge aclk);
        in_tvalid = 1'b1;
        in_tdata  = d;
        while (!in_tready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("accept_timeout", {23'd0, in_tready}, 24'd1);
        @(posedge aclk);
        #1;
        in_tvalid = 1'b0;
    endtask

    task automatic calibrate(input logic [23:0] sv, input logic [23:0] a0,
                             input logic [23:0] a1, input logic [23:0] old_b,
                             input logic [23:0] exp_b);
        int d0;
        @(negedge aclk);
        cal_start = 1'b1;
        @(posedge aclk);
        #1;
        cal_start = 1'b0;
        d0 = done_cnt;
        check("busy_start", {23'd0, cal_busy}, 24'd1);
        for (int i = 0; i < 2; i++) begin
            send(sv);
            check("busy_settle", {23'd0, cal_busy}, 24'd1);
        end
        for (int i = 0; i < 16; i++) begin
            send((i % 2) ? a1 : a0);
            check("busy_accum", {23'd0, cal_busy}, 24'd1);
            if (i == 0) check("no_fwd", {23'd0, out_tvalid}, 24'd0);
            if (i == 8) check("bias_hold", bias_out, old_b);
        end
        check("done_pulse", {23'd0, cal_done}, 24'd1);
        @(posedge aclk);
        #1;
        check("bias_new", bias_out, exp_b);
        check("busy_end", {23'd0, cal_busy}, 24'd0);
        check("done_end", {23'd0, cal_done}, 24'd0);
        check("done_count", 24'(done_cnt - d0), 24'd1);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        send(v.din);
        check({name, "_valid"}, {23'd0, out_tvalid}, 24'd1);
        check({name, "_data"}, out_tdata, v.dout);
    endtask

    initial begin
        idle_v[0] = '{24'd5, 24'd5};
        idle_v[1] = '{24'hFFFFF9, 24'hFFFFF9};
        idle_v[2] = '{24'h7FFFFF, 24'h7FFFFF};
        run_v[0]  = '{24'd150, 24'd50};
        run_v[1]  = '{24'd0, 24'hFFFF9C};
        run_v[2]  = '{24'd100, 24'd0};
`ifdef BIAS_CAL_SAT_EN
        run_v[3]  = '{24'h800000, 24'h800000};
`else
        run_v[3]  = '{24'h800000, 24'h7FFF9C};
`endif

        aresetn    = 1'b0;
        cal_start  = 1'b0;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        out_tready = 1'b1;
        #12;
        check("rst_busy", {23'd0, cal_busy}, 24'd0);
        check("rst_done", {23'd0, cal_done}, 24'd0);
        check("rst_valid", {23'd0, out_tvalid}, 24'd0);
        check("rst_bias", bias_out, 24'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 3; i++) run_vec("idle", idle_v[i]);
        check("idle_bias", bias_out, 24'd0);

        calibrate(24'd1000, 24'd100, 24'd100, 24'd0, 24'd100);
        for (int i = 0; i < 4; i++) run_vec("run", run_v[i]);

        calibrate(24'd0, 24'hFFFFFD, 24'hFFFFFC, 24'd100, 24'hFFFFFC);
        run_vec("floor", '{24'd150, 24'd154});

        calibrate(24'd7, 24'hFFFF9C, 24'hFFFF9C, 24'hFFFFFC, 24'hFFFF9C);
`ifdef BIAS_CAL_SAT_EN
        run_vec("sat", '{24'h7FFFF0, 24'h7FFFFF});
`else
        run_vec("wrap", '{24'h7FFFF0, 24'h800054});
`endif

        // Backpressure: one item held, second blocked until out_tready
        repeat (2) @(negedge aclk);
        out_tready = 1'b0;
        send(24'd7);
        check("bp_valid", {23'd0, out_tvalid}, 24'd1);
        check("bp_data", out_tdata, 24'd107);
        @(negedge aclk);
        in_tvalid = 1'b1;
        in_tdata  = 24'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", {23'd0, in_tready}, 24'd0);
            check("bp_hold", out_tdata, 24'd107);
            @(negedge aclk);
        end
        out_tready = 1'b1;
        #1;
        check("bp_release", {23'd0, in_tready}, 24'd1);
        @(posedge aclk);
        #1;
        in_tvalid = 1'b0;
        check("bp_next", out_tdata, 24'd109);

        // Reset in the middle of accumulation aborts the calibration
        @(negedge aclk);
        cal_start = 1'b1;
        @(posedge aclk);
        #1;
        cal_start = 1'b0;
        for (int i = 0; i < 7; i++) send(24'd50);
        check("abort_busy_pre", {23'd0, cal_busy}, 24'd1);
        begin
            int d0;
            d0 = done_cnt;
            @(negedge aclk);
            aresetn = 1'b0;
            #1;
            check("abort_busy", {23'd0, cal_busy}, 24'd0);
            check("abort_bias", bias_out, 24'd0);
            check("abort_done", {23'd0, cal_done}, 24'd0);
            @(negedge aclk);
            aresetn = 1'b1;
            repeat (20) @(negedge aclk);
            check("abort_no_done", 24'(done_cnt - d0), 24'd0);
        end
        run_vec("post_rst", '{24'd5, 24'd5});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bias_cal_sequencer.md
BIAS_CAL_SEQUENCER -- requirements
Module: bias_cal_sequencer

Interface
REQ-001 The block SHALL have parameter DataWidth, default 24, giving the sample width in bits (signed two's complement).
REQ-002 The block SHALL have parameter SampleBits, default 12, setting 2^SampleBits samples averaged per calibration.
REQ-003 The block SHALL have parameter SettleSamples, default 16, giving the number of accepted samples discarded before accumulation (0 allowed).
REQ-004 The block SHALL have these ports:
- aclk  in  1  single clock, all logic rising-edge
- aresetn  in  1  asynchronous active-low reset
- cal_start  in  1  request calibration, sampled each cycle
- cal_busy  out  1  high in SETTLE, ACCUM, UPDATE
- cal_done  out  1  one-cycle pulse on calibration completion
- bias_out  out  DataWidth  current bias value
- in_tvalid  in  1  input sample valid
- in_tready  out  1  input ready
- in_tdata  in  DataWidth  input sample
- out_tvalid  out  1  corrected sample valid
- out_tready  in  1  downstream ready
- out_tdata  out  DataWidth  corrected sample (in_tdata - bias)

Function
REQ-005 The FSM SHALL have states IDLE, SETTLE, ACCUM, UPDATE, RUN.
REQ-006 IDLE and RUN SHALL forward samples through a one-entry registered output stage: in_tready = !out_tvalid | out_tready; latency exactly 1 cycle from input handshake to out_tvalid.
REQ-007 IDLE SHALL forward with bias_out = 0 (bias is 0 until the first calibration completes); RUN SHALL forward with the calibrated bias_out.
REQ-008 cal_start=1 in IDLE or RUN SHALL move to SETTLE (or to ACCUM if SettleSamples=0) next cycle and clear the sample counter and accumulator; cal_start in any other state SHALL be ignored.
REQ-009 In SETTLE and ACCUM in_tready SHALL be 1; accepted samples SHALL NOT be forwarded; any item already held in the output stage SHALL remain valid and stable until out_tready.
REQ-010 SETTLE SHALL count SettleSamples accepted samples, then go to ACCUM.
REQ-011 ACCUM SHALL sign-extend and add 2^SampleBits accepted samples into a (DataWidth+SampleBits)-bit signed accumulator, then go to UPDATE.
REQ-012 UPDATE SHALL last one cycle: bias_out <= accumulator >>> SampleBits (arithmetic, floor toward negative infinity), cal_done = 1, then go to RUN.
REQ-013 bias_out SHALL change only in UPDATE or on reset; a new calibration from RUN keeps the old bias_out visible until its UPDATE.
REQ-014 The counter SHALL be sized so that max(SettleSamples, 2^SampleBits) does not wrap; there SHALL be no intermediate wrap-around.
REQ-015 Output subtraction SHALL be DataWidth-bit; the overflow behaviour is set by REQ-019.

Reset
REQ-016 aresetn low SHALL asynchronously force: state IDLE, bias_out 0, accumulator 0, counter 0, out_tvalid 0, cal_busy 0, cal_done 0; out_tdata value is don't-care.
REQ-017 Reset asserted mid-calibration SHALL abort it with no cal_done; after release the block behaves as after power-up.

Configuration
REQ-018 Macro BIAS_CAL_SAT_EN defined: out_tdata SHALL saturate to [-2^(DataWidth-1), 2^(DataWidth-1)-1].
REQ-019 Macro BIAS_CAL_SAT_EN undefined: out_tdata SHALL wrap modulo 2^DataWidth.

Structure
REQ-020 Package bias_cal_pkg SHALL hold the FSM state enum and a function returning the accumulator width (DataWidth+SampleBits).
REQ-021 The accumulator and its counter SHALL live in sub-module bias_cal_accum (clear, enable, sample in; sum and count out); the FSM and output stage stay at top level.

Verification (DataWidth=24, SampleBits=4, SettleSamples=2)
REQ-022 Reset release, send 5 with out_tready=1 -> out_tdata=5 one cycle later, bias_out=0.
REQ-023 cal_start, then 2x 1000 followed by 16x 100 -> cal_busy high throughout, bias_out=100, single cal_done pulse; then input 150 -> output 50.
REQ-024 Calibrate on 16 samples alternating -3/-4 (sum -56) -> bias_out=-4 (floor).
REQ-025 bias_out=-100, input 0x7FFFF0 -> 0x7FFFFF with BIAS_CAL_SAT_EN defined, 0x800054 without it.
REQ-026 RUN with out_tready=0 -> one item accepted, then in_tready=0; out_tdata stable until out_tready=1.
REQ-027 aresetn low after 5 ACCUM samples -> same cycle IDLE: cal_busy=0, bias_out=0, no cal_done.
